mat_mul_sched: RTL and testbench

- Sequencing controller for the matrix-multiply datapath: multiplier stage feeding the pipelined adder-tree stages.
- On `start`, walks every (row, col) output element of a MATRIX_DIM x MATRIX_DIM product.
- Issues one dot-product per cycle into the fixed-latency pipeline.
- Tracks in-flight elements with a delay line and produces the result write strobe/address when each sum emerges, then signals completion.

---
 rtl/mat_mul_sched_pkg.sv | 20 ++
 rtl/mat_mul_sched_if.sv | 26 ++
 rtl/mat_mul_sched_delay_line.sv | 47 ++++
 rtl/mat_mul_sched.sv | 65 ++++++
 tb/tb_mat_mul_sched.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mat_mul_sched_pkg.sv
// mat_mul_sched_pkg: shared FSM encoding, default sizing and index-width helper
// Exports: state_t, MATRIX_DIM_DEF, PIPE_LAT_DEF, IDX_W_DEF, idx_w()
`ifndef MATRIX_DIM
`define MATRIX_DIM 8
`endif
package mat_mul_sched_pkg;
    localparam int MATRIX_DIM_DEF = `MATRIX_DIM;
    localparam int PIPE_LAT_DEF = 4;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;
    // A 1-bit index is kept even for degenerate dimensions so ports never collapse to zero width
    function automatic int idx_w(input int dim);
        return dim > 1 ? $clog2(dim) : 1;
    endfunction
    localparam int IDX_W_DEF = idx_w(MATRIX_DIM_DEF);
endpackage

// File: rtl/mat_mul_sched_if.sv
// mat_mul_sched_if: control/status bundle between the scheduler and its environment
// master drives start/hold and observes issue/write/status; slave is the scheduler side
interface mat_mul_sched_if
    import mat_mul_sched_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF
);
    logic             start;
    logic             hold;
    logic             issue_valid;
    logic [IDX_W-1:0] row_idx;
    logic [IDX_W-1:0] col_idx;
    logic             wr_en;
    logic [IDX_W-1:0] wr_row;
    logic [IDX_W-1:0] wr_col;
    logic             busy;
    logic             done;
    modport master (
        output start, hold,
        input  issue_valid, row_idx, col_idx, wr_en, wr_row, wr_col, busy, done
    );
    modport slave (
        input  start, hold,
        output issue_valid, row_idx, col_idx, wr_en, wr_row, wr_col, busy, done
    );
endinterface

// File: rtl/mat_mul_sched_delay_line.sv
// sched_delay_line: DEPTH-stage {valid,row,col} shift register mirroring the datapath latency
// Ports: clk, rst (async clear), in_valid/in_row/in_col (stage 0 input),
// out_valid/out_row/out_col (tap at DEPTH), pending (valid anywhere except the tap)
module sched_delay_line #(
    parameter int DEPTH = 4,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_row,
    input  logic [W-1:0] in_col,
    output logic         out_valid,
    output logic [W-1:0] out_row,
    output logic [W-1:0] out_col,
    output logic         pending
);
    logic [DEPTH-1:0] vld;
    logic [W-1:0]     rows [DEPTH];
    logic [W-1:0]     cols [DEPTH];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rows[i] <= '0;
                cols[i] <= '0;
            end
        end else begin
            vld[0]  <= in_valid;
            rows[0] <= in_row;
            cols[0] <= in_col;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i]  <= vld[i-1];
                rows[i] <= rows[i-1];
                cols[i] <= cols[i-1];
            end
        end
    end
    // The tap is excluded: once only the tap is valid, the final write completes this cycle
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) pending = pending | vld[i];
    end
    assign out_valid = vld[DEPTH-1];
    assign out_row   = rows[DEPTH-1];
    assign out_col   = cols[DEPTH-1];
endmodule

// File: rtl/mat_mul_sched.sv
// mat_mul_sched: row-major issue sequencer and result-write tracker for the matrix-multiply pipeline
// Ports: clk, rst (async, active high); bus (slave): start, hold in;
// issue_valid, row_idx, col_idx, wr_en, wr_row, wr_col, busy, done out
module mat_mul_sched
    import mat_mul_sched_pkg::*;
#(
    parameter int MATRIX_DIM = MATRIX_DIM_DEF,
    parameter int PIPE_LAT   = PIPE_LAT_DEF,
    parameter int IDX_W      = idx_w(MATRIX_DIM)
) (
    input logic            clk,
    input logic            rst,
    mat_mul_sched_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(MATRIX_DIM - 1);
    state_t           state, state_n;
    logic [IDX_W-1:0] row, col;
    logic             issue, pend;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE) begin
                row <= '0;
                col <= '0;
            end else if (issue) begin
                // Power-of-two dimension: col wraps to 0 on its own, row then advances
                col <= col + 1'b1;
                row <= row + IDX_W'(col == LAST);
            end
        end
    end
    always_comb begin
        state_n = state;
        issue   = 1'b0;
        case (state)
            IDLE:  state_n = bus.start ? ISSUE : IDLE;
            ISSUE: begin
                issue   = !bus.hold;
                state_n = (issue && row == LAST && col == LAST) ? DRAIN : ISSUE;
            end
            DRAIN: state_n = pend ? DRAIN : DONE;
            DONE:  state_n = IDLE;
        endcase
    end
    sched_delay_line #(.DEPTH(PIPE_LAT), .W(IDX_W)) u_dl (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue),
        .in_row    (row),
        .in_col    (col),
        .out_valid (bus.wr_en),
        .out_row   (bus.wr_row),
        .out_col   (bus.wr_col),
        .pending   (pend)
    );
    assign bus.issue_valid = issue;
    assign bus.row_idx     = row;
    assign bus.col_idx     = col;
    assign bus.busy        = (state == ISSUE) || (state == DRAIN);
    assign bus.done        = (state == DONE);
endmodule

// File: tb/tb_mat_mul_sched.sv
// tb_mat_mul_sched: directed and randomized checks of mat_mul_sched against a transaction-level model
module tb_mat_mul_sched;
    localparam int D = 8;
    localparam int L = 4;
    localparam int W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mat_mul_sched_if #(.IDX_W(W)) bus ();
    mat_mul_sched_if #(.IDX_W(1)) bus2 ();
    mat_mul_sched #(.MATRIX_DIM(D), .PIPE_LAT(L), .IDX_W(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    mat_mul_sched #(.MATRIX_DIM(2), .PIPE_LAT(1), .IDX_W(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an active product issues element k=0..D*D-1 on each non-held cycle;
    // every issue schedules a write L cycles later; done follows the last write by one cycle.
    typedef struct {int due; int r; int c;} wr_t;
    wr_t wq[$];
    int  t = 0, k = 0, done_cyc = -1, base = 0, prev_base = 0;
    bit  active = 0;
    int  first_iv = -1, last_iv = 0, last_wr = 0, done_rel = 0;
    int  wr_cnt = 0, busy_cnt = 0, done_cnt = 0, tot_wr = 0, tot_done = 0;
    int  b2 = -100;
    logic [9:0] iv2 = '0, wr2 = '0, dn2 = '0, bz2 = '0;
    logic [7:0] seq2 = '0;

    always @(negedge clk) begin
        bit e_iv, e_wr;
        int r;
        t++;
        r = t - b2;
        if (r >= 0 && r < 10) begin
            iv2[r] = bus2.issue_valid;
            wr2[r] = bus2.wr_en;
            dn2[r] = bus2.done;
            bz2[r] = bus2.busy;
            if (bus2.wr_en) seq2 = {seq2[5:0], bus2.wr_row, bus2.wr_col};
        end
        if (rst) begin
            active = 0;
            k = 0;
            done_cyc = -1;
            wq.delete();
            chk("reset_outputs", 32'({bus.issue_valid, bus.wr_en, bus.busy, bus.done,
                bus.row_idx, bus.col_idx, bus.wr_row, bus.wr_col}), 0);
        end else begin
            e_iv = active && k < D * D && !bus.hold;
            e_wr = wq.size() > 0 && wq[0].due == t;
            chk("issue_valid", 32'(bus.issue_valid), 32'(e_iv));
            if (e_iv) chk("issue_idx", int'(bus.row_idx) * 16 + int'(bus.col_idx), (k / D) * 16 + k % D);
            chk("wr_en", 32'(bus.wr_en), 32'(e_wr));
            if (e_wr) begin
                chk("wr_idx", int'(bus.wr_row) * 16 + int'(bus.wr_col), wq[0].r * 16 + wq[0].c);
                void'(wq.pop_front());
            end
            chk("busy", 32'(bus.busy), 32'(active));
            chk("done", 32'(bus.done), 32'(t == done_cyc));
            if (bus.issue_valid) begin
                if (first_iv < 0) first_iv = t - base;
                last_iv = t - base;
            end
            if (bus.wr_en) begin
                wr_cnt++;
                tot_wr++;
                last_wr = t - base;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                tot_done++;
                done_rel = t - base;
            end
            if (e_iv) begin
                wq.push_back('{t + L, k / D, k % D});
                k++;
                if (k == D * D) done_cyc = t + L + 1;
            end
            if (active && t + 1 == done_cyc) active = 0;
            else if (!active && t != done_cyc && bus.start) begin
                active = 1;
                k = 0;
                prev_base = base;
                base = t;
                first_iv = -1;
                wr_cnt = 0;
                busy_cnt = 0;
                done_cnt = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int snap_wr, snap_done;
        bus.start = 0;
        bus.hold = 0;
        bus2.start = 0;
        bus2.hold = 0;
        repeat (3) step();
        rst = 0;
        step();

        // Plain product on both instances
        bus.start = 1;
        bus2.start = 1;
        b2 = t + 1;
        for (int r = 1; r <= 85; r++) begin
            step();
            bus.start = 0;
            bus2.start = 0;
        end
        chk("t1_first_issue", first_iv, 1);
        chk("t1_last_issue", last_iv, 64);
        chk("t1_last_wr", last_wr, 68);
        chk("t1_done", done_rel, 69);
        chk("t1_model_done", done_cyc - base, 69);
        chk("t1_wr_count", wr_cnt, 64);
        chk("t1_busy_cycles", busy_cnt, 68);
        chk("t1_done_count", done_cnt, 1);
        chk("d2_issue_mask", 32'(iv2), 32'h01E);
        chk("d2_wr_mask", 32'(wr2), 32'h03C);
        chk("d2_done_mask", 32'(dn2), 32'h040);
        chk("d2_busy_mask", 32'(bz2), 32'h03E);
        chk("d2_wr_order", 32'(seq2), 32'h1B);

        // Hold during issue
        step();
        bus.start = 1;
        for (int r = 1; r <= 85; r++) begin
            step();
            bus.start = 0;
            bus.hold = (r >= 10 && r <= 12);
        end
        chk("t2_last_issue", last_iv, 67);
        chk("t2_last_wr", last_wr, 71);
        chk("t2_done", done_rel, 72);
        chk("t2_wr_count", wr_cnt, 64);

        // Start re-asserted mid-product is ignored
        step();
        bus.start = 1;
        for (int r = 1; r <= 85; r++) begin
            step();
            bus.start = (r == 30 || r == 66);
        end
        chk("t3_done", done_rel, 69);
        chk("t3_wr_count", wr_cnt, 64);
        chk("t3_done_count", done_cnt, 1);

        // Async reset mid-product abandons in-flight results
        step();
        bus.start = 1;
        for (int r = 1; r <= 42; r++) begin
            step();
            bus.start = 0;
            if (r == 40) begin
                #2 rst = 1;
            end
            if (r == 42) rst = 0;
        end
        snap_wr = tot_wr;
        repeat (10) step();
        chk("t4_no_wr_after_rst", tot_wr, snap_wr);
        bus.start = 1;
        for (int r = 1; r <= 85; r++) begin
            step();
            bus.start = 0;
        end
        chk("t4_done", done_rel, 69);
        chk("t4_wr_count", wr_cnt, 64);

        // Start tied high: back-to-back products
        step();
        snap_wr = tot_wr;
        snap_done = tot_done;
        bus.start = 1;
        for (int r = 1; r <= 160; r++) begin
            step();
            bus.start = (r < 140);
        end
        chk("t5_restart_gap", base - prev_base, 70);
        chk("t5_total_wr", tot_wr - snap_wr, 128);
        chk("t5_total_done", tot_done - snap_done, 2);

        // Randomized start/hold with occasional async reset
        for (int r = 0; r < 3000; r++) begin
            step();
            if (rst) rst = 0;
            bus.start = ($urandom_range(0, 15) == 0);
            bus.hold = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1;
            end
        end
        step();
        rst = 0;
        bus.start = 0;
        bus.hold = 0;
        repeat (120) step();
        chk("end_idle", 32'({bus.busy, bus.wr_en, bus.issue_valid}), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
